uart_word_rx: RTL

Serial ingress stage feeding the 32-bit FIFO on the Arty A7 board. Receives 8N1 UART bytes on the USB-UART RX pin, assembles each group of four bytes into one little-endian word, and presents it on the FIFO write port with a single-cycle `enable_write` strobe. Partial words stalled beyond a timeout are discarded. The block has no backpressure: the FIFO write port is fire-and-forget.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 136 +++++++++++++
 rtl/uart_word_rx.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions.
// Contents: byte FSM state encoding, the 100 MHz / 115200 baud bit period,
// and a helper that turns a word width into a byte count.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_115200 = 868;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    // Number of bytes that make up one output word.
    function automatic int unsigned bytes_per_word(input int unsigned bit_depth);
        return bit_depth / 8;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizer, byte FSM and bit counter.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   rx_serial       - asynchronous UART line, idle high
//   byte_valid_c    - 1-cycle pulse during the stop-bit sample when stop = 1
//   byte_data       - received byte, stable from the last data bit onwards
//   frame_error_c   - 1-cycle pulse during the stop-bit sample when stop = 0
//   busy            - registered, high whenever the FSM is not in IDLE
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic       byte_valid_c,
    output logic [7:0] byte_data,
    output logic       frame_error_c,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             meta_q;
    logic             rx_s_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             busy_q, busy_d;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            meta_q <= rx_serial;
            rx_s_q <= meta_q;
        end
    end

    // Byte FSM next-state and strobes.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        byte_valid_c  = 1'b0;
        frame_error_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                // Re-check the line at the middle of the start bit.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        byte_valid_c = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        frame_error_c = 1'b1;
                        state_d       = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must not be taken as new start bits.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
        end
    end

    assign byte_data = shift_q;
    assign busy      = busy_q;

endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver: packs groups of BIT_DEPTH/8 bytes (little-endian) into
// one word and strobes it onto a FIFO write port. Stalled partial words are
// dropped after TIMEOUT_BITS idle bit-times.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   rx_serial       - asynchronous UART line, idle high
//   enable_write    - 1-cycle strobe, value_to_write holds a new word
//   value_to_write  - last completed word
//   frame_error     - 1-cycle pulse on a bad stop bit
//   busy            - high while a frame is being received
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int unsigned BIT_DEPTH    = 32,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic                 enable_write,
    output logic [BIT_DEPTH-1:0] value_to_write,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int unsigned BYTES      = bytes_per_word(BIT_DEPTH);
    localparam int unsigned K_W        = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned IDLE_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned IDLE_W     = $clog2(IDLE_LIMIT + 1);

    logic                 byte_valid_c;
    logic [7:0]           byte_data;
    logic                 byte_frame_error_c;
    logic                 byte_busy;

    logic [K_W-1:0]       k_q, k_d;
    logic [BIT_DEPTH-1:0] shadow_q, shadow_d;
    logic [BIT_DEPTH-1:0] value_q, value_d;
    logic                 enable_write_q, enable_write_d;
    logic                 frame_error_q, frame_error_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk           (clk),
        .rst           (rst),
        .rx_serial     (rx_serial),
        .byte_valid_c  (byte_valid_c),
        .byte_data     (byte_data),
        .frame_error_c (byte_frame_error_c),
        .busy          (byte_busy)
    );

    // Word assembly, partial-word timeout and output strobes.
    always_comb begin
        k_d            = k_q;
        shadow_d       = shadow_q;
        value_d        = value_q;
        enable_write_d = 1'b0;
        frame_error_d  = byte_frame_error_c;
        idle_d         = idle_q;

        // Idle counter only runs with a partial word and the FSM in IDLE.
        if (byte_busy || (k_q == '0)) begin
            idle_d = '0;
        end else if (idle_q == IDLE_W'(IDLE_LIMIT)) begin
            idle_d   = '0;
            k_d      = '0;
            shadow_d = '0;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end

        if (byte_frame_error_c) begin
            k_d      = '0;
            shadow_d = '0;
        end else if (byte_valid_c) begin
            shadow_d[{k_q, 3'b000} +: 8] = byte_data;
            if (k_q == K_W'(BYTES - 1)) begin
                value_d        = shadow_d;
                enable_write_d = 1'b1;
                k_d            = '0;
                shadow_d       = '0;
            end else begin
                k_d = k_q + K_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q            <= '0;
            shadow_q       <= '0;
            value_q        <= '0;
            enable_write_q <= 1'b0;
            frame_error_q  <= 1'b0;
            idle_q         <= '0;
        end else begin
            k_q            <= k_d;
            shadow_q       <= shadow_d;
            value_q        <= value_d;
            enable_write_q <= enable_write_d;
            frame_error_q  <= frame_error_d;
            idle_q         <= idle_d;
        end
    end

    assign enable_write   = enable_write_q;
    assign value_to_write = value_q;
    assign frame_error    = frame_error_q;
    assign busy           = byte_busy;

endmodule
